// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// and the mux/ALU select codes driven onto the datapath.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUSRCB_REGB  = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_SHIMM = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bundle between the state register and the control decoder.
// The master side supplies the (reset-qualified) state and the two status
// flags; the slave side returns every datapath control for that state.
// There is no valid/ready handshake: all signals are level, same-cycle.
interface multicycle_ctrl_if;
    logic [3:0] state;
    logic       mem_ready;
    logic       zero;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcen;

    modport master (
        output state, mem_ready, zero,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, aluop, pcsrc, pcen
    );

    modport slave (
        input  state, mem_ready, zero,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, aluop, pcsrc, pcen
    );
endinterface

// File: rtl/mc_outdec.sv
// Combinational state-to-controls decoder. Every control is a function of
// state alone, except the FETCH enables (gated by mem_ready so a stalled
// fetch loads IR/PC exactly once) and pcen (branch taken on zero).
module mc_outdec
    import multicycle_ctrl_pkg::*;
(
    multicycle_ctrl_if.slave bus
);

    logic pcwrite;
    logic branch;

    // Decode the current state into datapath controls; all default to 0.
    always_comb begin
        bus.iord     = 1'b0;
        bus.memwrite = 1'b0;
        bus.irwrite  = 1'b0;
        bus.regdst   = 1'b0;
        bus.memtoreg = 1'b0;
        bus.regwrite = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = ALUSRCB_REGB;
        bus.aluop    = ALUOP_ADD;
        bus.pcsrc    = PCSRC_ALU;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        case (bus.state)
            S_FETCH: begin
                bus.alusrcb = ALUSRCB_FOUR;
                bus.irwrite = bus.mem_ready;
                pcwrite     = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alusrcb = ALUSRCB_SHIMM;
            end
            S_MEMADR, S_ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = ALUSRCB_IMM;
            end
            S_MEMRD: begin
                bus.iord = 1'b1;
            end
            S_MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
            end
            S_MEMWR: begin
                // Held through stall cycles until memory accepts the write.
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                bus.alusrca = 1'b1;
                bus.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            S_BRANCH: begin
                bus.alusrca = 1'b1;
                bus.aluop   = ALUOP_SUB;
                bus.pcsrc   = PCSRC_ALUOUT;
                branch      = 1'b1;
            end
            S_ADDIWB: begin
                bus.regwrite = 1'b1;
            end
            S_JUMP: begin
                bus.pcsrc = PCSRC_JUMP;
                pcwrite   = 1'b1;
            end
            default: begin
                bus.alusrcb = ALUSRCB_REGB;
            end
        endcase
        bus.pcen = pcwrite | (branch & bus.zero);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor main controller: state register and next-state
// logic live here; control outputs come from the mc_outdec decoder.
// While reset is high the decoder sees FETCH with mem_ready forced low, so
// only alusrcb=01 is visible and no enable can fire.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;
    logic   illegal_d;

    multicycle_ctrl_if bus ();

    // State register; reset overrides any pending transition, stalls included.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; op is only looked at in DECODE and MEMADR.
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW)      state_d = S_MEMRD;
                else if (op == OP_SW) state_d = S_MEMWR;
                else                  state_d = S_FETCH;
            end
            S_MEMRD: begin
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Reset-qualified view of the state handed to the decoder.
    assign bus.state     = reset ? S_FETCH : state_q;
    assign bus.mem_ready = mem_ready & ~reset;
    assign bus.zero      = zero & ~reset;

    mc_outdec u_outdec (
        .bus (bus.slave)
    );

    assign iord     = bus.iord;
    assign memwrite = bus.memwrite;
    assign irwrite  = bus.irwrite;
    assign regdst   = bus.regdst;
    assign memtoreg = bus.memtoreg;
    assign regwrite = bus.regwrite;
    assign alusrca  = bus.alusrca;
    assign alusrcb  = bus.alusrcb;
    assign aluop    = bus.aluop;
    assign pcsrc    = bus.pcsrc;
    assign pcen     = bus.pcen;
    assign illegal  = illegal_d & ~reset;
    assign state    = bus.state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-cycle vector table walking every
// instruction class, followed by stall-length sequences counting pulses.
module tb_multicycle_ctrl;

    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    // Control word: iord memwrite irwrite regdst memtoreg regwrite alusrca
    //               _ alusrcb _ aluop _ pcsrc _ pcen illegal
    localparam logic [14:0] C_RST  = 15'b0000000_01_00_00_00;
    localparam logic [14:0] C_FST  = 15'b0000000_01_00_00_00;
    localparam logic [14:0] C_FGO  = 15'b0010000_01_00_00_10;
    localparam logic [14:0] C_DEC  = 15'b0000000_11_00_00_00;
    localparam logic [14:0] C_DILL = 15'b0000000_11_00_00_01;
    localparam logic [14:0] C_MADR = 15'b0000001_10_00_00_00;
    localparam logic [14:0] C_MRD  = 15'b1000000_00_00_00_00;
    localparam logic [14:0] C_MWB  = 15'b0000110_00_00_00_00;
    localparam logic [14:0] C_MWR  = 15'b1100000_00_00_00_00;
    localparam logic [14:0] C_EXE  = 15'b0000001_00_10_00_00;
    localparam logic [14:0] C_AWB  = 15'b0001010_00_00_00_00;
    localparam logic [14:0] C_BRT  = 15'b0000001_00_01_01_10;
    localparam logic [14:0] C_BRN  = 15'b0000001_00_01_01_00;
    localparam logic [14:0] C_AIEX = 15'b0000001_10_00_00_00;
    localparam logic [14:0] C_AIWB = 15'b0000010_00_00_00_00;
    localparam logic [14:0] C_JMP  = 15'b0000000_00_00_10_10;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        zero;
        logic        mr;
        logic [3:0]  st;
        logic [14:0] ctl;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       illegal;
    int         errors;
    int         checks;
    vec_t       tbl[$];

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .zero      (bus.zero),
        .mem_ready (bus.mem_ready),
        .iord      (bus.iord),
        .memwrite  (bus.memwrite),
        .irwrite   (bus.irwrite),
        .regdst    (bus.regdst),
        .memtoreg  (bus.memtoreg),
        .regwrite  (bus.regwrite),
        .alusrca   (bus.alusrca),
        .alusrcb   (bus.alusrcb),
        .aluop     (bus.aluop),
        .pcsrc     (bus.pcsrc),
        .pcen      (bus.pcen),
        .illegal   (illegal),
        .state     (bus.state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] act_ctl();
        return {bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
                bus.regwrite, bus.alusrca, bus.alusrcb, bus.aluop, bus.pcsrc,
                bus.pcen, illegal};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [5:0] o, input logic z,
                       input logic m, input logic [3:0] s, input logic [14:0] c);
        vec_t v;
        v.rst = r; v.op = o; v.zero = z; v.mr = m; v.st = s; v.ctl = c;
        tbl.push_back(v);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int k;
        int cnt_irw;
        int cnt_pcen;
        int cnt_mw;
        int cnt_rw;
        int stall;
        bit visited;
        bit done;

        errors = 0;
        checks = 0;
        reset = 1'b1;
        op = LW;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;

        // Reset, then lw
        add(1, LW, 0, 1, 0, C_RST);
        add(1, LW, 0, 0, 0, C_RST);
        add(0, LW, 0, 0, 0, C_FST);
        add(0, LW, 0, 1, 0, C_FGO);
        add(0, LW, 0, 1, 1, C_DEC);
        add(0, LW, 0, 1, 2, C_MADR);
        add(0, LW, 0, 1, 3, C_MRD);
        add(0, LW, 0, 1, 4, C_MWB);
        // sw with three stall cycles in MEMWR
        add(0, SW, 0, 1, 0, C_FGO);
        add(0, SW, 0, 1, 1, C_DEC);
        add(0, SW, 0, 1, 2, C_MADR);
        add(0, SW, 0, 0, 5, C_MWR);
        add(0, SW, 0, 0, 5, C_MWR);
        add(0, SW, 0, 0, 5, C_MWR);
        add(0, SW, 0, 1, 5, C_MWR);
        // R-type; op changes after DECODE and must be ignored
        add(0, RT, 0, 1, 0, C_FGO);
        add(0, RT, 0, 1, 1, C_DEC);
        add(0, BAD, 0, 1, 6, C_EXE);
        add(0, BAD, 0, 1, 7, C_AWB);
        // addi
        add(0, ADDI, 0, 1, 0, C_FGO);
        add(0, ADDI, 0, 1, 1, C_DEC);
        add(0, ADDI, 0, 1, 9, C_AIEX);
        add(0, ADDI, 0, 1, 10, C_AIWB);
        // beq taken, then not taken
        add(0, BEQ, 1, 1, 0, C_FGO);
        add(0, BEQ, 1, 1, 1, C_DEC);
        add(0, BEQ, 1, 1, 8, C_BRT);
        add(0, BEQ, 0, 1, 0, C_FGO);
        add(0, BEQ, 0, 1, 1, C_DEC);
        add(0, BEQ, 0, 1, 8, C_BRN);
        // j
        add(0, J, 0, 1, 0, C_FGO);
        add(0, J, 0, 1, 1, C_DEC);
        add(0, J, 0, 1, 11, C_JMP);
        // illegal opcode, then a 5-cycle fetch stall
        add(0, BAD, 0, 1, 0, C_FGO);
        add(0, BAD, 0, 1, 1, C_DILL);
        for (int i = 0; i < 5; i++) add(0, LW, 0, 0, 0, C_FST);
        add(0, LW, 0, 1, 0, C_FGO);
        // reset during a stalled MEMRD
        add(0, LW, 0, 1, 1, C_DEC);
        add(0, LW, 0, 1, 2, C_MADR);
        add(0, LW, 0, 0, 3, C_MRD);
        add(1, LW, 0, 0, 0, C_RST);
        add(0, LW, 0, 0, 0, C_FST);
        add(0, LW, 0, 1, 0, C_FGO);
        add(0, LW, 0, 1, 1, C_DEC);

        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            op = tbl[i].op;
            bus.zero = tbl[i].zero;
            bus.mem_ready = tbl[i].mr;
            @(negedge clk);
            check($sformatf("vec%0d_state", i), 32'(bus.state), 32'(tbl[i].st));
            check($sformatf("vec%0d_ctl", i), 32'(act_ctl()), 32'(tbl[i].ctl));
            next_cycle();
        end

        // Random-length fetch stall: exactly one irwrite and one pcen
        do_reset();
        op = RT;
        bus.zero = 1'b0;
        n = $urandom_range(1, 8);
        cnt_irw = 0;
        cnt_pcen = 0;
        for (int c = 0; c < n + 2; c++) begin
            bus.mem_ready = (c < n) ? 1'b0 : 1'b1;
            @(negedge clk);
            cnt_irw += int'(bus.irwrite);
            cnt_pcen += int'(bus.pcen);
            next_cycle();
        end
        @(negedge clk);
        check("fetch_stall_irwrite_count", 32'(cnt_irw), 32'd1);
        check("fetch_stall_pcen_count", 32'(cnt_pcen), 32'd1);
        check("fetch_stall_then_execute", 32'(bus.state), 32'd6);
        next_cycle();

        // sw with random MEMWR stall: memwrite held k+1 cycles, no regwrite
        do_reset();
        op = SW;
        k = $urandom_range(0, 5);
        stall = 0;
        visited = 1'b0;
        done = 1'b0;
        cnt_mw = 0;
        cnt_rw = 0;
        bus.mem_ready = 1'b1;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            if (bus.state == 4'd5 && stall < k) begin
                bus.mem_ready = 1'b0;
                stall++;
            end else begin
                bus.mem_ready = 1'b1;
            end
            #1;
            if (bus.state == 4'd5) visited = 1'b1;
            if (visited && bus.state == 4'd0) done = 1'b1;
            cnt_mw += int'(bus.memwrite);
            cnt_rw += int'(bus.regwrite);
            @(posedge clk);
        end
        check("sw_stall_reached_fetch", 32'(done), 32'd1);
        check("sw_stall_memwrite_count", 32'(cnt_mw), 32'(k + 1));
        check("sw_stall_regwrite_count", 32'(cnt_rw), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
